// File: rtl/display7seg_scan_pkg.sv
// rtl/display7seg_scan_pkg.sv - shared types and constants for the 7-segment scanner
package display7seg_scan_pkg;

    typedef enum logic {
        S_GUARD = 1'b0,
        S_DRIVE = 1'b1
    } slot_state_e;

    // Common-anode display: a high anode or dp line means dark.
    localparam logic AN_OFF = 1'b1;
    localparam logic DP_OFF = 1'b1;

    function automatic bit params_legal(input int n_digits, input int clk_div, input int guard);
        return (n_digits >= 1) && (clk_div >= 2) && (guard >= 0) && (guard < clk_div);
    endfunction

endpackage

// File: rtl/display7seg_slot_timer.sv
// rtl/display7seg_slot_timer.sv - slot/digit counters and guard/drive phase FSM
module display7seg_slot_timer
    import display7seg_scan_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int CLK_DIV  = 50000,
    parameter int GUARD    = 16,
    localparam int SW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1,
    localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [IW-1:0] idx_o,
    output logic [IW-1:0] idx_nxt_o,
    output logic          in_guard_o,
    output logic          in_guard_nxt_o,
    output logic          slot_last_o,
    output logic          frame_last_o,
    output logic          frame_last_nxt_o
);

    localparam logic [SW-1:0] SLOT_LAST = SW'(CLK_DIV - 1);
    localparam logic [SW-1:0] GUARD_CNT = SW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
    localparam slot_state_e   RST_STATE = (GUARD > 0) ? S_GUARD : S_DRIVE;

    logic [SW-1:0] slot_q, slot_d;
    logic [IW-1:0] idx_q, idx_d;
    slot_state_e   state_q, state_d;
    logic          slot_last;

    always_comb begin
        slot_last = (slot_q == SLOT_LAST);
        slot_d    = slot_last ? '0 : slot_q + SW'(1);
        idx_d     = idx_q;
        if (slot_last) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q  <= '0;
            idx_q   <= '0;
            state_q <= RST_STATE;
        end else begin
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    // Phase of the slot that begins on the next edge; GUARD=0 never enters S_GUARD.
    always_comb begin
        state_d = S_DRIVE;
        if (slot_d < GUARD_CNT) begin
            state_d = S_GUARD;
        end
    end

    always_comb begin
        in_guard_o       = (state_q == S_GUARD);
        in_guard_nxt_o   = (state_d == S_GUARD);
        idx_o            = idx_q;
        idx_nxt_o        = idx_d;
        slot_last_o      = slot_last;
        frame_last_o     = slot_last && (idx_q == IDX_LAST);
        frame_last_nxt_o = (slot_d == SLOT_LAST) && (idx_d == IDX_LAST);
    end

endmodule

// File: rtl/display7seg_scan.sv
// rtl/display7seg_scan.sv - frame-synchronous N-digit 7-segment scanner with guard and blanking
module display7seg_scan
    import display7seg_scan_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int CLK_DIV  = 50000,
    parameter int GUARD    = 16,
    parameter int LZB      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [3:0]            digit_code,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  frame_done
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic LZB_EN = (LZB != 0);

    if (!params_legal(N_DIGITS, CLK_DIV, GUARD)) begin : g_bad_params
        $error("display7seg_scan: need N_DIGITS >= 1, CLK_DIV >= 2 and 0 <= GUARD < CLK_DIV");
    end

    logic [IW-1:0] idx_cur, idx_nxt;
    logic          in_guard_cur, in_guard_nxt;
    logic          slot_last, frame_last, frame_last_nxt;

    display7seg_slot_timer #(
        .N_DIGITS (N_DIGITS),
        .CLK_DIV  (CLK_DIV),
        .GUARD    (GUARD)
    ) u_timer (
        .clk_i            (clk),
        .rst_i            (rst),
        .idx_o            (idx_cur),
        .idx_nxt_o        (idx_nxt),
        .in_guard_o       (in_guard_cur),
        .in_guard_nxt_o   (in_guard_nxt),
        .slot_last_o      (slot_last),
        .frame_last_o     (frame_last),
        .frame_last_nxt_o (frame_last_nxt)
    );

    logic [4*N_DIGITS-1:0] shadow_val_q, shadow_val_d, active_val_q, active_val_d;
    logic [N_DIGITS-1:0]   shadow_blank_q, shadow_blank_d, active_blank_q, active_blank_d;
    logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
    logic                  pending_q, pending_d;

    // Active only changes on the frame boundary; a boundary load skips the shadow hop.
    always_comb begin
        shadow_val_d   = shadow_val_q;
        shadow_blank_d = shadow_blank_q;
        shadow_dp_d    = shadow_dp_q;
        active_val_d   = active_val_q;
        active_blank_d = active_blank_q;
        active_dp_d    = active_dp_q;
        pending_d      = pending_q;
        if (load) begin
            shadow_val_d   = value_in;
            shadow_blank_d = blank_in;
            shadow_dp_d    = dp_in;
        end
        if (frame_last) begin
            pending_d = 1'b0;
            if (load) begin
                active_val_d   = value_in;
                active_blank_d = blank_in;
                active_dp_d    = dp_in;
            end else if (pending_q) begin
                active_val_d   = shadow_val_q;
                active_blank_d = shadow_blank_q;
                active_dp_d    = shadow_dp_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    logic [N_DIGITS-1:0] lz, dark;
    logic                zero_run;

    // A digit is leading-zero blanked when it and every more significant nibble is zero.
    always_comb begin
        zero_run = 1'b1;
        lz       = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & (active_val_d[4*k +: 4] == 4'h0);
            if (k != 0) begin
                lz[k] = LZB_EN & zero_run;
            end
        end
        dark = active_blank_d | lz;
    end

    logic [N_DIGITS-1:0] an_n_q, an_n_d;
    logic                dp_n_q, dp_n_d;
    logic [3:0]          digit_code_q, digit_code_d;
    logic                frame_done_q, frame_done_d;

    // Outputs are computed from the post-edge counters so the flops show the current slot.
    always_comb begin
        an_n_d       = {N_DIGITS{AN_OFF}};
        dp_n_d       = DP_OFF;
        digit_code_d = active_val_d[{idx_nxt, 2'b00} +: 4];
        frame_done_d = frame_last_nxt;
        if (!in_guard_nxt) begin
            dp_n_d = ~active_dp_d[idx_nxt];
            if (!dark[idx_nxt]) begin
                an_n_d[idx_nxt] = ~AN_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val_q   <= '0;
            shadow_blank_q <= '0;
            shadow_dp_q    <= '0;
            active_val_q   <= '0;
            active_blank_q <= '0;
            active_dp_q    <= '0;
            pending_q      <= 1'b0;
            an_n_q         <= {N_DIGITS{AN_OFF}};
            dp_n_q         <= DP_OFF;
            digit_code_q   <= 4'h0;
            frame_done_q   <= 1'b0;
        end else begin
            shadow_val_q   <= shadow_val_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_dp_q    <= shadow_dp_d;
            active_val_q   <= active_val_d;
            active_blank_q <= active_blank_d;
            active_dp_q    <= active_dp_d;
            pending_q      <= pending_d;
            an_n_q         <= an_n_d;
            dp_n_q         <= dp_n_d;
            digit_code_q   <= digit_code_d;
            frame_done_q   <= frame_done_d;
        end
    end

    logic unused_timer;
    assign unused_timer = ^{idx_cur, in_guard_cur, slot_last};

    assign an_n       = an_n_q;
    assign dp_n       = dp_n_q;
    assign digit_code = digit_code_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display7seg_scan.sv
// tb/tb_display7seg_scan.sv - directed self-checking bench for display7seg_scan
module tb_display7seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_code;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    display7seg_scan #(
        .N_DIGITS (4),
        .CLK_DIV  (8),
        .GUARD    (2),
        .LZB      (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value_in   (value_in),
        .blank_in   (blank_in),
        .dp_in      (dp_in),
        .digit_code (digit_code),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic count_to_frame_done(input string tag, input int exp_steps);
        int n;
        n = 0;
        while (n < 64) begin
            step();
            n++;
            if (frame_done === 1'b1) break;
        end
        check(tag, n, exp_steps);
    endtask

    // Entered at the negedge of a boundary cycle; walks one full frame (32 cycles).
    task automatic check_frame(input logic [15:0] exp_val, input logic [15:0] exp_an,
                               input logic [3:0] exp_dp,
                               input int l1_at, input logic [15:0] l1_val,
                               input logic [3:0] l1_blank, input logic [3:0] l1_dp,
                               input int l2_at, input logic [15:0] l2_val,
                               input logic [3:0] l2_blank, input logic [3:0] l2_dp);
        int s;
        int c;
        logic [3:0] e_an;
        logic       e_dp;
        frame_no++;
        for (int i = 0; i < 32; i++) begin
            step();
            load = 1'b0;
            s = i / 8;
            c = i % 8;
            e_an = (c < 2) ? 4'hF : exp_an[4*s +: 4];
            e_dp = (c < 2) ? 1'b1 : ~exp_dp[s];
            check($sformatf("an_f%0d_c%0d", frame_no, i), an_n, e_an);
            check($sformatf("code_f%0d_c%0d", frame_no, i), digit_code, exp_val[4*s +: 4]);
            check($sformatf("dp_f%0d_c%0d", frame_no, i), dp_n, e_dp);
            check($sformatf("fd_f%0d_c%0d", frame_no, i), frame_done, (i == 31) ? 1 : 0);
            if (i == l1_at) begin
                load = 1'b1; value_in = l1_val; blank_in = l1_blank; dp_in = l1_dp;
            end
            if (i == l2_at) begin
                load = 1'b1; value_in = l2_val; blank_in = l2_blank; dp_in = l2_dp;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", an_n, 4'hF);
        check("rst_dp", dp_n, 1'b1);
        check("rst_code", digit_code, 4'h0);
        check("rst_fd", frame_done, 1'b0);
        rst = 1'b0;

        count_to_frame_done("first_fd_gap", 31);
        count_to_frame_done("second_fd_gap", 32);

        // Power-up frame: all zero, only digit 0 lit; load 1234 mid-frame.
        check_frame(16'h0000, 16'hFFFE, 4'h0, 7, 16'h1234, 4'h0, 4'h0, -1, '0, '0, '0);
        // 1234 shown untouched while two loads arrive; the second (ABCD, dp1) must win.
        check_frame(16'h1234, 16'h7BDE, 4'h0, 3, 16'h5555, 4'h0, 4'h0, 18, 16'hABCD, 4'h0, 4'h2);
        check_frame(16'hABCD, 16'h7BDE, 4'h2, 10, 16'h0050, 4'h0, 4'h0, -1, '0, '0, '0);
        // Leading-zero blanking; boundary load of 00F0 overrides the 0050 already active.
        check_frame(16'h0050, 16'hFFDE, 4'h0, 31, 16'h00F0, 4'h0, 4'h0, -1, '0, '0, '0);
        check_frame(16'h00F0, 16'hFFDE, 4'h0, 5, 16'h1234, 4'h4, 4'h1, -1, '0, '0, '0);
        // Forced blank of digit 2 and decimal point on digit 0.
        check_frame(16'h1234, 16'h7FDE, 4'h1, -1, '0, '0, '0, -1, '0, '0, '0);

        repeat (5) step();
        check("pre_rst_an", an_n, 4'hE);
        check("pre_rst_dp", dp_n, 1'b0);
        check("pre_rst_code", digit_code, 4'h4);
        rst = 1'b1;
        load = 1'b1;
        value_in = 16'hFFFF;
        blank_in = 4'h0;
        dp_in = 4'hF;
        step();
        rst = 1'b0;
        load = 1'b0;
        check("mid_rst_an", an_n, 4'hF);
        check("mid_rst_dp", dp_n, 1'b1);
        check("mid_rst_code", digit_code, 4'h0);
        check("mid_rst_fd", frame_done, 1'b0);
        count_to_frame_done("post_rst_fd_gap", 31);
        check_frame(16'h0000, 16'hFFFE, 4'h0, -1, '0, '0, '0, -1, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
